// File: rtl/comp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
//   comp_state_e : controller states (IDLE, RUN, DONE)
//   comp_flags_t : packed {eq, lt, gt} compare flags
//   FLAGS_RST    : flag value held while in reset (all clear)
//   FLAGS_INIT   : flag value loaded on accept (operands equal so far)
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } comp_state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } comp_flags_t;

  localparam comp_flags_t FLAGS_RST  = '{eq: 1'b0, lt: 1'b0, gt: 1'b0};
  localparam comp_flags_t FLAGS_INIT = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};

endpackage

// File: rtl/comp_slice.sv
// Combinational compare of one SLICE-bit chunk, chaining single-bit
// eq/lt/gt cells from MSB to LSB. Incoming flags carry the verdict of the
// more significant bits; a decided verdict (lt or gt) passes through.
// Ports:
//   a_s, b_s        in  SLICE  operand chunks
//   eq_in/lt_in/gt_in in 1     verdict from more significant bits
//   eq_out/lt_out/gt_out out 1 verdict including this chunk
module comp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             gt_in,
  output logic             eq_out,
  output logic             lt_out,
  output logic             gt_out
);

  logic eq_c, lt_c, gt_c;

  always_comb begin
    eq_c = eq_in;
    lt_c = lt_in;
    gt_c = gt_in;
    for (int i = SLICE - 1; i >= 0; i--) begin
      // first differing bit while still equal decides the verdict for good
      if (eq_c && (a_s[i] != b_s[i])) begin
        eq_c = 1'b0;
        lt_c = b_s[i];
        gt_c = a_s[i];
      end
    end
  end

  assign eq_out = eq_c;
  assign lt_out = lt_c;
  assign gt_out = gt_c;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands
// MSB-first, SLICE bits per cycle, with optional two's-complement mode and
// valid/ready handshakes on both sides.
// Optional build macro: COMP_EARLY_EXIT_EN -- finish as soon as the verdict
// is decided instead of always walking all NSLICE slices.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a, b, is_signed     operands and mode, sampled on accept
//   out_valid/out_ready result handshake
//   eq, lt, gt          result flags, one-hot while out_valid
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | comparing one slice per cycle, top slice first
// DONE  | result held until out_ready
module seq_magnitude_comparator
  import comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("seq_magnitude_comparator: SLICE must divide WIDTH");
    end
  endgenerate

  comp_state_e      state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IDXW-1:0]  idx;
  comp_flags_t      flags, slice_flags;
  logic             accept, decided;

  assign accept = in_valid && in_ready;

  // Operand registers shift left each RUN cycle, so the slice under
  // compare is always the top SLICE bits.
  comp_slice #(.SLICE(SLICE)) u_slice (
    .a_s    (a_r[WIDTH-1 -: SLICE]),
    .b_s    (b_r[WIDTH-1 -: SLICE]),
    .eq_in  (flags.eq),
    .lt_in  (flags.lt),
    .gt_in  (flags.gt),
    .eq_out (slice_flags.eq),
    .lt_out (slice_flags.lt),
    .gt_out (slice_flags.gt)
  );

`ifdef COMP_EARLY_EXIT_EN
  assign decided = slice_flags.lt || slice_flags.gt;
`else
  assign decided = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if ((idx == '0) || decided) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      idx   <= IDX_TOP;
      flags <= FLAGS_RST;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // flipping the sign bit maps two's-complement order onto unsigned order
            a_r   <= is_signed ? (a ^ SIGN_BIT) : a;
            b_r   <= is_signed ? (b ^ SIGN_BIT) : b;
            idx   <= IDX_TOP;
            flags <= FLAGS_INIT;
          end
        end
        RUN: begin
          flags <= slice_flags;
          a_r   <= a_r << SLICE;
          b_r   <= b_r << SLICE;
          idx   <= idx - IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign eq = flags.eq;
  assign lt = flags.lt;
  assign gt = flags.gt;

endmodule
